// File: rtl/knn_vote.sv
// knn_vote: snapshots the sorted K-nearest list, streams its valid entries over a
// valid/ready port, then reports the majority label among the streamed entries.
module knn_vote #(
    parameter  int DATA_W      = 32,
    parameter  int NUMBER_VIZI = 10,
    parameter  int LABEL_W     = 4,
    localparam int NCLASS      = 2 ** LABEL_W,
    localparam int CNT_W       = $clog2(NUMBER_VIZI + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUMBER_VIZI*DATA_W-1:0]  list_dist,
    input  logic [NUMBER_VIZI*LABEL_W-1:0] list_label,
    input  logic                           rd_ready,
    output logic                           busy,
    output logic                           rd_valid,
    output logic [DATA_W-1:0]              rd_dist,
    output logic [LABEL_W-1:0]             rd_label,
    output logic                           rd_last,
    output logic                           done,
    output logic [LABEL_W-1:0]             result_label,
    output logic [CNT_W-1:0]               result_votes,
    output logic [CNT_W-1:0]               result_count,
    output logic                           result_empty
);
    localparam int IDX_W = CNT_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_READ = 3'd2,
        S_VOTE = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef logic [NUMBER_VIZI-1:0][DATA_W-1:0]  dist_arr_t;
    typedef logic [NUMBER_VIZI-1:0][LABEL_W-1:0] label_arr_t;
    typedef logic [NCLASS-1:0][CNT_W-1:0]        cnt_arr_t;

    // Loop-based muxes keep the index width independent of the slot count.
    function automatic logic [DATA_W-1:0] pick_dist(input dist_arr_t d, input logic [IDX_W-1:0] i);
        pick_dist = '0;
        for (int j = 0; j < NUMBER_VIZI; j++)
            pick_dist = (i == IDX_W'(j)) ? d[j] : pick_dist;
    endfunction

    function automatic logic [LABEL_W-1:0] pick_label(input label_arr_t l, input logic [IDX_W-1:0] i);
        pick_label = '0;
        for (int j = 0; j < NUMBER_VIZI; j++)
            pick_label = (i == IDX_W'(j)) ? l[j] : pick_label;
    endfunction

    // Last beat: final slot, or the following slot holds the all-ones empty marker.
    function automatic logic is_last(input dist_arr_t d, input logic [IDX_W-1:0] i);
        is_last = (i == IDX_W'(NUMBER_VIZI - 1));
        for (int j = 1; j < NUMBER_VIZI; j++)
            is_last = is_last | ((i == IDX_W'(j - 1)) && (d[j] == '1));
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    dist_arr_t          snap_dist_q, snap_dist_d;
    label_arr_t         snap_label_q, snap_label_d;
    cnt_arr_t           cnt_q, cnt_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic [LABEL_W-1:0] cls_q, cls_d;
    logic [LABEL_W-1:0] best_label_q, best_label_d;
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic               busy_q, busy_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_dist_q, rd_dist_d;
    logic [LABEL_W-1:0] rd_label_q, rd_label_d;
    logic               rd_last_q, rd_last_d;
    logic               done_q, done_d;
    logic [LABEL_W-1:0] result_label_q, result_label_d;
    logic [CNT_W-1:0]   result_votes_q, result_votes_d;
    logic [CNT_W-1:0]   result_count_q, result_count_d;
    logic               result_empty_q, result_empty_d;

    logic               xfer_s;
    logic               better_s;
    logic [CNT_W-1:0]   cur_cnt_s;
    logic [LABEL_W-1:0] win_label_s;
    logic [CNT_W-1:0]   win_cnt_s;

    // Next-state, snapshot, vote counting and registered-output computation.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        snap_dist_d    = snap_dist_q;
        snap_label_d   = snap_label_q;
        cnt_d          = cnt_q;
        rcnt_d         = rcnt_q;
        cls_d          = cls_q;
        best_label_d   = best_label_q;
        best_cnt_d     = best_cnt_q;
        result_label_d = result_label_q;
        result_votes_d = result_votes_q;
        result_count_d = result_count_q;
        result_empty_d = result_empty_q;

        xfer_s      = rd_valid_q & rd_ready;
        cur_cnt_s   = cnt_q[cls_q];
        better_s    = (cur_cnt_s > best_cnt_q);
        win_label_s = better_s ? cls_q : best_label_q;
        win_cnt_s   = better_s ? cur_cnt_s : best_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    snap_dist_d  = list_dist;
                    snap_label_d = list_label;
                    cnt_d        = '0;
                    idx_d        = '0;
                    rcnt_d       = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                cls_d        = '0;
                best_label_d = '0;
                best_cnt_d   = '0;
                state_d      = (snap_dist_q[0] == '1) ? S_VOTE : S_READ;
            end
            S_READ: begin
                if (xfer_s) begin
                    cnt_d[rd_label_q] = cnt_q[rd_label_q] + CNT_W'(1);
                    rcnt_d            = rcnt_q + CNT_W'(1);
                    idx_d             = idx_q + IDX_W'(1);
                    state_d           = rd_last_q ? S_VOTE : S_READ;
                end else begin
                    state_d = S_READ;
                end
            end
            S_VOTE: begin
                // Strictly-greater replacement keeps the lowest label on ties.
                best_label_d = win_label_s;
                best_cnt_d   = win_cnt_s;
                cls_d        = cls_q + LABEL_W'(1);
                if (cls_q == '1) begin
                    state_d        = S_DONE;
                    result_count_d = rcnt_q;
                    result_empty_d = (rcnt_q == '0);
                    result_label_d = (rcnt_q == '0) ? '0 : win_label_s;
                    result_votes_d = (rcnt_q == '0) ? '0 : win_cnt_s;
                end else begin
                    state_d = S_VOTE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d == S_LOAD) || (state_d == S_READ) || (state_d == S_VOTE);
        done_d     = (state_d == S_DONE);
        rd_valid_d = (state_d == S_READ);
        rd_dist_d  = rd_valid_d ? pick_dist(snap_dist_d, idx_d) : '0;
        rd_label_d = rd_valid_d ? pick_label(snap_label_d, idx_d) : '0;
        rd_last_d  = rd_valid_d ? is_last(snap_dist_d, idx_d) : 1'b0;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            snap_dist_q    <= '0;
            snap_label_q   <= '0;
            cnt_q          <= '0;
            rcnt_q         <= '0;
            cls_q          <= '0;
            best_label_q   <= '0;
            best_cnt_q     <= '0;
            busy_q         <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_dist_q      <= '0;
            rd_label_q     <= '0;
            rd_last_q      <= 1'b0;
            done_q         <= 1'b0;
            result_label_q <= '0;
            result_votes_q <= '0;
            result_count_q <= '0;
            result_empty_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            snap_dist_q    <= snap_dist_d;
            snap_label_q   <= snap_label_d;
            cnt_q          <= cnt_d;
            rcnt_q         <= rcnt_d;
            cls_q          <= cls_d;
            best_label_q   <= best_label_d;
            best_cnt_q     <= best_cnt_d;
            busy_q         <= busy_d;
            rd_valid_q     <= rd_valid_d;
            rd_dist_q      <= rd_dist_d;
            rd_label_q     <= rd_label_d;
            rd_last_q      <= rd_last_d;
            done_q         <= done_d;
            result_label_q <= result_label_d;
            result_votes_q <= result_votes_d;
            result_count_q <= result_count_d;
            result_empty_q <= result_empty_d;
        end
    end

    assign busy         = busy_q;
    assign rd_valid     = rd_valid_q;
    assign rd_dist      = rd_dist_q;
    assign rd_label     = rd_label_q;
    assign rd_last      = rd_last_q;
    assign done         = done_q;
    assign result_label = result_label_q;
    assign result_votes = result_votes_q;
    assign result_count = result_count_q;
    assign result_empty = result_empty_q;

endmodule
